r22sdf_bitrev: RTL

- Output reorder stage that sits directly downstream of the last r22sdf_mod stage.
- The R22SDF pipeline emits FFT bins in bit-reversed index order. This block buffers each frame in a ping-pong memory and replays it in natural order, 0..fft_length-1.
- It also generates frame framing (valid, start-of-frame, bin index) for downstream consumers.

---
 rtl/r22sdf_bitrev.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/r22sdf_bitrev.sv
// rtl/r22sdf_bitrev.sv - ping-pong reorder buffer turning bit-reversed R22SDF output into natural order
//
// Purpose: buffers each fft_length-point frame coming out of the last R22SDF stage
// (bit-reversed bin order) and replays it in natural bin order 0..fft_length-1,
// together with valid / start-of-frame / bin index framing.
//
// Ports:
//   sys_clk     in   clock, rising edge
//   sys_nrst    in   asynchronous active-low reset
//   sys_en      in   global enable; low freezes all state, memory writes and outputs
//   din_valid   in   sample present on din_r/din_i (qualified by sys_en)
//   din_r/din_i in   real/imag sample, bit-reversed bin order
//   dout_valid  out  dout_* carry a valid natural-order bin (qualify with sys_en)
//   dout_sof    out  high with bin 0 of each frame
//   dout_idx    out  natural bin index
//   dout_r/dout_i out real/imag sample, natural bin order
module r22sdf_bitrev #(
   parameter int data_resolution = 16,
   parameter int fft_length      = 16,
   localparam int L              = $clog2(fft_length)
) (
   input  logic                       sys_clk,
   input  logic                       sys_nrst,
   input  logic                       sys_en,
   input  logic                       din_valid,
   input  logic [data_resolution-1:0] din_r,
   input  logic [data_resolution-1:0] din_i,
   output logic                       dout_valid,
   output logic                       dout_sof,
   output logic [L-1:0]               dout_idx,
   output logic [data_resolution-1:0] dout_r,
   output logic [data_resolution-1:0] dout_i
);

   localparam int DW = 2 * data_resolution;
   localparam logic [L-1:0] LAST_BIN = L'(fft_length - 1);

   typedef enum logic {
      RD_IDLE,
      RD_STREAM
   } rd_state_t;

   function automatic logic [L-1:0] bitrev(input logic [L-1:0] x);
      logic [L-1:0] y;
      y = '0;
      for (int k = 0; k < L; k++) begin
         y[k] = x[L-1-k];
      end
      return y;
   endfunction

   // Two banks back to back: address = {bank, bin position}
   logic [DW-1:0]        mem_q [2*fft_length];

   logic [L-1:0]         wr_cnt_q, wr_cnt_d;
   logic                 wr_bank_q, wr_bank_d;
   logic [1:0]           bank_full_q, bank_full_d;
   rd_state_t            state_q, state_d;
   logic [L-1:0]         rd_cnt_q, rd_cnt_d;
   logic                 rd_bank_q, rd_bank_d;

   logic                 accept;
   logic                 wr_last;
   logic                 rd_issue;
   logic                 rd_wrap;

   // Read pipeline: memory read register, then output register
   logic [DW-1:0]        rd_data_q;
   logic                 rd_vld_q;
   logic [L-1:0]         rd_idx_q;

   logic                       dout_valid_q;
   logic                       dout_sof_q;
   logic [L-1:0]               dout_idx_q;
   logic [data_resolution-1:0] dout_r_q;
   logic [data_resolution-1:0] dout_i_q;

   assign accept  = sys_en & din_valid;
   assign wr_last = (wr_cnt_q == LAST_BIN);

   always_comb begin
      wr_cnt_d  = wr_cnt_q;
      wr_bank_d = wr_bank_q;
      if (accept) begin
         wr_cnt_d = wr_cnt_q + 1'b1;
         if (wr_last) begin
            wr_bank_d = ~wr_bank_q;
         end
      end
   end

   // Reader: issuing straight from IDLE in the cycle the flag is seen keeps
   // back-to-back frames gap-free even though the writer's flag for the next
   // bank lands in the same cycle the reader wraps.
   always_comb begin
      state_d   = state_q;
      rd_cnt_d  = rd_cnt_q;
      rd_bank_d = rd_bank_q;
      rd_issue  = 1'b0;
      rd_wrap   = 1'b0;
      unique case (state_q)
         RD_IDLE: begin
            if (sys_en && bank_full_q[rd_bank_q]) begin
               rd_issue = 1'b1;
               state_d  = RD_STREAM;
            end
         end
         RD_STREAM: begin
            if (sys_en) begin
               rd_issue = 1'b1;
            end
         end
      endcase
      if (rd_issue) begin
         rd_cnt_d = rd_cnt_q + 1'b1;
         if (rd_cnt_q == LAST_BIN) begin
            rd_wrap   = 1'b1;
            rd_bank_d = ~rd_bank_q;
            state_d   = bank_full_q[~rd_bank_q] ? RD_STREAM : RD_IDLE;
         end
      end
   end

   // Writer and reader always work on different banks, so set and clear never collide
   always_comb begin
      bank_full_d = bank_full_q;
      if (rd_wrap) begin
         bank_full_d[rd_bank_q] = 1'b0;
      end
      if (accept && wr_last) begin
         bank_full_d[wr_bank_q] = 1'b1;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_nrst) begin
      if (!sys_nrst) begin
         wr_cnt_q     <= '0;
         wr_bank_q    <= 1'b0;
         bank_full_q  <= 2'b00;
         state_q      <= RD_IDLE;
         rd_cnt_q     <= '0;
         rd_bank_q    <= 1'b0;
         rd_vld_q     <= 1'b0;
         rd_idx_q     <= '0;
         dout_valid_q <= 1'b0;
         dout_sof_q   <= 1'b0;
         dout_idx_q   <= '0;
         dout_r_q     <= '0;
         dout_i_q     <= '0;
      end else begin
         wr_cnt_q    <= wr_cnt_d;
         wr_bank_q   <= wr_bank_d;
         bank_full_q <= bank_full_d;
         state_q     <= state_d;
         rd_cnt_q    <= rd_cnt_d;
         rd_bank_q   <= rd_bank_d;
         if (sys_en) begin
            rd_vld_q     <= rd_issue;
            if (rd_issue) begin
               rd_idx_q <= rd_cnt_q;
            end
            dout_valid_q <= rd_vld_q;
            // Data/index/sof hold their last values while no bin is flowing
            if (rd_vld_q) begin
               dout_idx_q <= rd_idx_q;
               dout_sof_q <= (rd_idx_q == '0);
               dout_r_q   <= rd_data_q[DW-1:data_resolution];
               dout_i_q   <= rd_data_q[data_resolution-1:0];
            end
         end
      end
   end

   // Storage has no reset; its contents after reset are never read before rewritten
   always_ff @(posedge sys_clk) begin
      if (accept) begin
         mem_q[{wr_bank_q, wr_cnt_q}] <= {din_r, din_i};
      end
      if (rd_issue) begin
         rd_data_q <= mem_q[{rd_bank_q, bitrev(rd_cnt_q)}];
      end
   end

   assign dout_valid = dout_valid_q;
   assign dout_sof   = dout_sof_q;
   assign dout_idx   = dout_idx_q;
   assign dout_r     = dout_r_q;
   assign dout_i     = dout_i_q;

endmodule
